// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg: shared state type and width helper for the sequential right shifter
package seq_shift_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int aw_of(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/shift1_right.sv
// shift1_right: one-bit right shift with zero or sign fill
module shift1_right #(
  parameter int N     = 8,
  parameter int ARITH = 0
) (
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_d
);
  assign o_d = {(ARITH != 0) & i_d[N-1], i_d[N-1:1]};
endmodule

// File: rtl/seq_right_shifter.sv
// seq_right_shifter: multi-cycle right shifter, one bit per cycle, valid/ready on both sides
module seq_right_shifter
  import seq_shift_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int ARITH = 0,
  localparam int AW    = aw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);
  state_t        r_state;
  logic [N-1:0]  r_work;
  logic [AW-1:0] r_cnt;
  logic [N-1:0]  w_next;
  logic [AW-1:0] w_amt;
  // N shifts already yield all-fill, so larger distances only cost latency
  assign w_amt = (in_amt >= AW'(N)) ? AW'(N) : in_amt;
  shift1_right #(.N(N), .ARITH(ARITH)) u_step (.i_d(r_work), .o_d(w_next));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_work  <= in_data;
          r_cnt   <= w_amt;
          r_state <= (w_amt == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          r_work  <= w_next;
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == AW'(1)) ? DONE : SHIFT;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_work;
endmodule

// File: tb/tb_seq_right_shifter.sv
// tb_seq_right_shifter: directed and random checks of logical (inst 0) and arithmetic (inst 1) shifters
module tb_seq_right_shifter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid[2], out_ready[2], in_ready[2], out_valid[2], busy[2];
  logic [7:0] in_data[2], out_data[2];
  logic [3:0] in_amt[2];
  logic [7:0] sb[$];
  int n_cmp = 0, n_err = 0, n_acc = 0, n_res = 0;

  always #5 clk = ~clk;

  seq_right_shifter #(.N(8), .ARITH(0)) u_log (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_amt(in_amt[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  seq_right_shifter #(.N(8), .ARITH(1)) u_ari (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_amt(in_amt[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  function automatic logic [7:0] model(int k, logic [7:0] d, logic [3:0] a);
    int s;
    s = (a > 4'd8) ? 8 : int'(a);
    return (k != 0) ? 8'($signed(d) >>> s) : (d >> s);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // returns on the first negedge after the accept edge
  task automatic send(int k, logic [7:0] d, logic [3:0] a);
    int c = 0;
    @(negedge clk);
    while (!in_ready[k] && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("in_ready_before_send", 32'(in_ready[k]), 1);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_amt[k]   = a;
    @(posedge clk);
    sb.push_back(model(k, d, a));
    n_acc++;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = 8'($urandom);
    in_amt[k]   = 4'($urandom);
    chk("busy_after_accept", 32'(busy[k]), 1);
    chk("in_ready_after_accept", 32'(in_ready[k]), 0);
  endtask

  task automatic collect(int k, int lat, int hold);
    int c = 1;
    logic [7:0] e;
    while (!out_valid[k] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("latency", c, lat);
    chk("out_valid", 32'(out_valid[k]), 1);
    e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk("out_data", 32'(out_data[k]), 32'(e));
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = 8'($urandom);
      in_amt[k]   = 4'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid[k]), 1);
      chk("hold_data", 32'(out_data[k]), 32'(e));
      chk("hold_in_ready", 32'(in_ready[k]), 0);
    end
    out_ready[k] = 1'b1;
    @(posedge clk);
    n_res++;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("idle_after_handshake", 32'(busy[k]), 0);
    chk("valid_low_after_handshake", 32'(out_valid[k]), 0);
    in_valid[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int k, h;
    logic [7:0] d;
    logic [3:0] a;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0; in_amt[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 32'(out_valid[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_out_data", 32'(out_data[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready0", 32'(in_ready[0]), 1);
    chk("rst_in_ready1", 32'(in_ready[1]), 1);

    send(0, 8'hB4, 4'd3);  collect(0, 4, 2);
    send(1, 8'hB4, 4'd3);  collect(1, 4, 0);
    send(1, 8'hB4, 4'd0);  collect(1, 1, 0);
    send(0, 8'hB4, 4'd12); collect(0, 9, 0);
    send(1, 8'h80, 4'd12); collect(1, 9, 0);
    send(0, 8'h5A, 4'd8);  collect(0, 9, 0);
    send(1, 8'h7F, 4'd7);  collect(1, 8, 0);
    send(0, 8'hC3, 4'd2);  collect(0, 3, 5);

    send(0, 8'hFF, 4'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid[0]), 0);
    chk("midrst_busy", 32'(busy[0]), 0);
    chk("midrst_out_data", 32'(out_data[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    n_acc--;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= out_valid[0];
    end
    chk("midrst_no_output", 32'(seen), 0);
    chk("midrst_idle", 32'(in_ready[0]), 1);
    send(0, 8'h0F, 4'd1);  collect(0, 2, 0);

    for (int i = 0; i < 30; i++) begin
      k = i % 2;
      d = 8'($urandom);
      a = 4'($urandom_range(0, 15));
      h = $urandom_range(0, 2);
      send(k, d, a);
      collect(k, ((a > 4'd8) ? 8 : int'(a)) + 1, h);
    end
    chk("results_vs_accepts", n_res, n_acc);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_right_shifter.md
SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

Interface
REQ-001 Parameter N, default 8, data width in bits (N >= 2).
REQ-002 Parameter ARITH, default 0; 0 = logical (zero fill), 1 = arithmetic (sign fill from input bit N-1).
REQ-003 Derived constant AW = clog2(N)+1, shift-amount width; amounts up to 2N-1 are representable.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream offers in_data/in_amt.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_data  input  N  operand.
REQ-009 in_amt  input  AW  right-shift distance.
REQ-010 out_valid  output  1  out_data holds a finished result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  N  shifted result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready = 1; in_valid & in_ready at an edge captures in_data into the working register and in_amt into the remaining-count register.
REQ-016 IDLE transition on accept: captured amount 0 -> DONE; otherwise -> SHIFT.
REQ-017 SHIFT: each cycle, working register shifts right one bit, fill bit per ARITH (sign fill uses the captured operand's bit N-1), and the count decrements by 1.
REQ-018 SHIFT -> DONE on the edge where the count reaches 0; latency from accept to out_valid = amt+1 cycles, clipped per REQ-019.
REQ-019 Amount >= N: the result is all zeros (logical) or all copies of the sign bit (arithmetic); the block SHALL clip the count to N at capture, so latency is at most N+1.
REQ-020 DONE: out_valid = 1, out_data = working register, both stable until out_valid & out_ready at an edge, then -> IDLE.
REQ-021 in_ready SHALL be 0 in SHIFT and DONE; no request is accepted while busy.
REQ-022 DONE -> IDLE and a new accept SHALL NOT occur on the same edge; minimum throughput is one result per amt+2 cycles.
REQ-023 out_data SHALL equal in_data >> in_amt (logical or arithmetic per ARITH) for every accepted request.
REQ-024 Input signals are ignored outside IDLE; changes to in_data/in_amt after acceptance do not affect the result.

Reset
REQ-025 While rst_n = 0: state = IDLE, in_ready = 1 once released, out_valid = 0, busy = 0, out_data = 0, count = 0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no output; the first cycle after release is IDLE.

Structure
REQ-027 A shared package seq_shift_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and the AW width function.
REQ-028 The one-bit shift step with fill SHALL be a sub-module shift1_right (parameters N, ARITH; purely combinational); the FSM, counter and handshake live in the top.

Verification
REQ-029 N=8, ARITH=0: in_data=0xB4, in_amt=3 accepted -> out_valid rises 4 cycles later with out_data=0x16; held until out_ready.
REQ-030 N=8, ARITH=1: in_data=0xB4, in_amt=3 -> out_data=0xF6; in_amt=0 -> out_data=0xB4 after 1 cycle.
REQ-031 N=8, ARITH=0, in_amt=12 -> out_data=0x00 after 9 cycles; ARITH=1 with in_data=0x80 -> 0xFF.
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready=0, in_valid pulses ignored; a new request is accepted only after the handshake cycle.
REQ-033 rst_n pulsed low during SHIFT (in_data=0xFF, in_amt=7) -> out_valid never asserted for that request, state IDLE; the next request 0x0F >> 1 returns 0x07.
REQ-034 Randomized back-to-back requests against a reference model -> every result matches REQ-023; count of results equals count of accepts.
